xadc_drp_scheduler: RTL

XADC_DRP_SCHEDULER -- requirements
Module: xadc_drp_scheduler

---
 rtl/xadc_drp_scheduler.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler
//   Arbitrates the XADC DRP port between an automatic scan engine and a host.
//   Each end-of-conversion (eoc) triggers one DRP read of the next enabled
//   scan channel (round-robin from pointer sel). Results are masked to a
//   12-bit value with the noise-floor LSBs cleared. Host accesses use the
//   port whenever no scan read is pending. Every DRP access is guarded by a
//   timeout counter.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET     clock, synchronous active-high reset
//   ch_en[3:0], eoc              scan channel enable mask, conversion done
//   drp_den/dwe/daddr/di         DRP request outputs (registered)
//   drp_do, drp_drdy             DRP read data and ready
//   host_req/we/addr/wdata       host request (level, held until host_ack)
//   host_ack/rdata/err           host completion pulse, read data, timeout
//   result[47:0], res_valid[3:0] per-channel 12-bit results and update pulses
//   ovr_clr, overrun             sticky lost-eoc flag and its clear
//   scan_err                     pulse on scan-read timeout
module xadc_drp_scheduler #(
  parameter int TIMEOUT  = 255,
  parameter int MASK_LSB = 4
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic [3:0]  ch_en,
  input  logic        eoc,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_err,
  output logic [47:0] result,
  output logic [3:0]  res_valid,
  input  logic        ovr_clr,
  output logic        overrun,
  output logic        scan_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_SCAN, WAIT_HOST} state_t;

  // DRP address of scan channel ch.
  function automatic logic [6:0] ch_addr(input logic [1:0] ch);
    case (ch)
      2'd0:    ch_addr = 7'h1E;
      2'd1:    ch_addr = 7'h17;
      2'd2:    ch_addr = 7'h1F;
      default: ch_addr = 7'h16;
    endcase
  endfunction

  // Clears the noise-floor LSBs of a 12-bit conversion result.
  function automatic logic [11:0] mask_result(input logic [11:0] raw);
    logic [11:0] keep;
    keep = 12'hFFF << MASK_LSB;
    mask_result = raw & keep;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              eoc_pend_q, eoc_pend_d;
  logic              overrun_q, overrun_d;
  logic [47:0]       result_q, result_d;
  logic [15:0]       host_rdata_q, host_rdata_d;
  logic              host_wr_q, host_wr_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic [6:0]        daddr_q, daddr_d;
  logic [15:0]       di_q, di_d;
  logic              host_ack_q, host_ack_d;
  logic              host_err_q, host_err_d;
  logic [3:0]        res_valid_q, res_valid_d;
  logic              scan_err_q, scan_err_d;

  logic              found;
  logic [1:0]        pick;
  logic [1:0]        idx;
  logic              consume;

  // First enabled channel at or after sel, searching cyclically.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int off = 0; off < 4; off++) begin
      idx = sel_q + 2'(off);
      if (!found && ch_en[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    host_rdata_d = host_rdata_q;
    host_wr_d    = host_wr_q;
    den_d        = 1'b0;
    dwe_d        = 1'b0;
    daddr_d      = daddr_q;
    di_d         = di_q;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    res_valid_d  = 4'b0000;
    scan_err_d   = 1'b0;
    consume      = 1'b0;

    case (state_q)
      IDLE: begin
        if (eoc_pend_q) begin
          // The pending eoc is consumed even when no channel is enabled.
          consume = 1'b1;
          if (found) begin
            den_d   = 1'b1;
            daddr_d = ch_addr(pick);
            ch_d    = pick;
            cnt_d   = '0;
            state_d = WAIT_SCAN;
          end
        // An eoc arriving this cycle also outranks the host, and the host is
        // not re-served in its own ack cycle while it is still dropping req.
        end else if (host_req && !eoc && !host_ack_q) begin
          den_d     = 1'b1;
          dwe_d     = host_we;
          daddr_d   = host_addr;
          di_d      = host_wdata;
          host_wr_d = host_we;
          cnt_d     = '0;
          state_d   = WAIT_HOST;
        end
      end
      WAIT_SCAN: begin
        if (drp_drdy) begin
          for (int i = 0; i < 4; i++) begin
            if (ch_q == 2'(i)) begin
              result_d[12*i +: 12] = mask_result(drp_do[15:4]);
              res_valid_d[i]       = 1'b1;
            end
          end
          sel_d   = ch_q + 2'd1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) begin
            scan_err_d = 1'b1;
            sel_d      = ch_q + 2'd1;
            state_d    = IDLE;
          end
        end
      end
      WAIT_HOST: begin
        if (drp_drdy) begin
          if (!host_wr_q) host_rdata_d = drp_do;
          host_ack_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) begin
            host_ack_d = 1'b1;
            host_err_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new eoc while an unconsumed one is still pending is a lost sample.
    eoc_pend_d = eoc | (eoc_pend_q & ~consume);
    overrun_d  = (eoc & eoc_pend_q & ~consume) | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      ch_q         <= 2'd0;
      cnt_q        <= '0;
      eoc_pend_q   <= 1'b0;
      overrun_q    <= 1'b0;
      result_q     <= '0;
      host_rdata_q <= '0;
      host_wr_q    <= 1'b0;
      den_q        <= 1'b0;
      dwe_q        <= 1'b0;
      daddr_q      <= '0;
      di_q         <= '0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      res_valid_q  <= '0;
      scan_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      eoc_pend_q   <= eoc_pend_d;
      overrun_q    <= overrun_d;
      result_q     <= result_d;
      host_rdata_q <= host_rdata_d;
      host_wr_q    <= host_wr_d;
      den_q        <= den_d;
      dwe_q        <= dwe_d;
      daddr_q      <= daddr_d;
      di_q         <= di_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      res_valid_q  <= res_valid_d;
      scan_err_q   <= scan_err_d;
    end
  end

  assign drp_den    = den_q;
  assign drp_dwe    = dwe_q;
  assign drp_daddr  = daddr_q;
  assign drp_di     = di_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign host_err   = host_err_q;
  assign result     = result_q;
  assign res_valid  = res_valid_q;
  assign overrun    = overrun_q;
  assign scan_err   = scan_err_q;

endmodule
